io_mux_ctrl: RTL and testbench
==============================

Name: io_mux_ctrl

Overview:
- Parametrised memory-mapped I/O controller: the CPU writes and reads registers on the data-memory bus.
- Drives a time-multiplexed N-digit seven-segment display, a parametrised LED bank, and a synchronised switch input.
- Sits beside data memory on the core's store/load path, decoded by address window.
- Adds over the static per-digit display: scanning, read-back, a control register and input sampling.

Parameters:
- BASE_ADDR, 32: byte address of register 0; register window is BASE_ADDR..BASE_ADDR+15, word aligned.
- NUM_DIGITS, 4: number of digits scanned, 1..8; SEG register uses nibbles [4*NUM_DIGITS-1:0].
- LED_WIDTH, 16: LED outputs, 1..32.
- SW_WIDTH, 16: switch inputs, 1..32.
- REFRESH_DIV, 50000: clk cycles each digit is held active, >= 2.
- DEBOUNCE_CYCLES, 250000: stability window; used only with IO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- io_addr  in  32  byte address from core
- io_data_in  in  32  write data
- io_w_en  in  1  write strobe, one cycle per store
- io_r_en  in  1  read strobe, one cycle per load
- io_data_out  out  32  registered read data
- io_r_valid  out  1  read data valid pulse
- sw_in  in  SW_WIDTH  asynchronous switch pins
- seg_out  out  7  segments a..g, active-low, bit0=a
- an_out  out  NUM_DIGITS  digit enables, active-low
- led_out  out  LED_WIDTH  LED drive, active-high

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 SEG: rw, hex value to display.
  - 0x4 LED: rw, bits [LED_WIDTH-1:0].
  - 0x8 SW: ro, synchronised switches zero-extended; writes ignored.
  - 0xC CTRL: rw; bit0 DISP_EN, bit1 BLANK_LZ; other bits read 0.
- Address decode: exact match of io_addr against BASE_ADDR+offset. Non-aligned or out-of-window addresses are ignored for writes and return 0 on reads. io_r_valid still pulses for in-window aligned reads only.
- Writes take effect on the clk edge where io_w_en=1. The value is visible on outputs and read-back from the next cycle. Unused upper bits are stored as 0.
- Reads have latency 1: io_r_en at cycle T gives io_data_out and io_r_valid=1 at T+1. io_data_out holds its last value otherwise. A simultaneous read and write to the same register returns the old value.
- Reset values: SEG=0, LED=0, CTRL=0x1, io_data_out=0, io_r_valid=0, scan counter=0, digit index=0, switch sync regs=0.
  - led_out=0 and an_out=all ones until the first scan cycle completes the reset.
  - Reset mid-scan returns to digit 0 immediately.
- Scan: a prescale counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0). Outputs are registered.
  - an_out has exactly one bit low, for the current index.
  - seg_out is the hex decode of nibble[index].
- DISP_EN=0: an_out all ones, seg_out all ones. The scan counter keeps running.
- BLANK_LZ=1: digits above the most significant nonzero nibble are blanked (seg_out all ones, anode still driven). Digit 0 is never blanked; value 0 shows "0".
- Switches: two-flop synchroniser; SW reads the second stage.

Optional Feature:
- Macro: IO_DEBOUNCE_EN.
- Defined: each synchronised switch bit updates SW only after holding a new level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts that bit's counter. The counter resets to 0.
- Undefined: SW = second synchroniser stage, latency 2 cycles; DEBOUNCE_CYCLES unused, no counters synthesised.

Decomposition:
- Package io_pkg holds:
  - register offsets SEG_OFS=0, LED_OFS=4, SW_OFS=8, CTRL_OFS=12;
  - CTRL bit indices;
  - the 16-entry hex-to-segment constant table (active-low).
- One sub-module, digit_scanner: prescaler, digit index, anode and segment registers, blanking logic. Top keeps decode, registers, read mux and switch input.

Test Plan:
- Reset then read 0xC (addr BASE+12) -> io_r_valid one cycle later, data 0x1; an_out=4'b1111 during reset, led_out=0.
- Write 0x0000ABCD to SEG, REFRESH_DIV=4 -> an_out cycles 1110,1101,1011,0111 every 4 cycles; seg_out shows D,C,B,A; then wraps to 1110.
- Write 0x00000005 with CTRL=0x3 -> only digit 0 shows 5; digits 1-3 seg_out=7'h7F; write CTRL=0 -> an_out=1111.
- Write LED 0xFFFF_FFFF with LED_WIDTH=16 -> led_out=16'hFFFF, readback 0x0000FFFF; write to BASE+8 and BASE+2 -> no register changes, read BASE+2 returns 0.
- Drive sw_in=16'h00A5 -> SW reads 0xA5 after 2 cycles; with IO_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch is never seen, a stable change appears after 8+2 cycles.
- Simultaneous io_w_en and io_r_en to LED (old 0x1, new 0x2) -> read returns 0x1, next read 0x2; rst asserted mid-scan -> digit index 0 and all registers at reset values next cycle.

Source files
------------

// File: rtl/io_mux_ctrl_pkg.sv
// Shared constants for the memory-mapped I/O controller: register offsets,
// CTRL bit positions and the active-low hex-to-seven-segment table.
package io_pkg;

  localparam logic [31:0] SEG_OFS  = 32'd0;
  localparam logic [31:0] LED_OFS  = 32'd4;
  localparam logic [31:0] SW_OFS   = 32'd8;
  localparam logic [31:0] CTRL_OFS = 32'd12;

  localparam int CTRL_DISP_EN  = 0;
  localparam int CTRL_BLANK_LZ = 1;

  // Segment patterns, bit0 = a ... bit6 = g, 0 = segment lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/io_mux_ctrl_digit_scanner.sv
// Time-multiplexed seven-segment scanner: prescaler, digit index, leading-zero
// blanking and registered anode/segment drive.
module digit_scanner
  import io_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    disp_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      msd;
  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  blank;

  // msd stays 0 for an all-zero value, so digit 0 always shows "0".
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] != 4'h0) msd = i[IDX_W-1:0];
    end
    cur_nib = digits[4*int'(idx) +: 4];
    onehot  = '0;
    onehot[idx] = 1'b1;
    blank   = blank_lz && (idx > msd);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      an_out  <= '1;
      seg_out <= SEG_BLANK;
    end else begin
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an_out  <= disp_en ? ~onehot : '1;
      seg_out <= (!disp_en || blank) ? SEG_BLANK : HEX_SEG[cur_nib];
    end
  end

endmodule

// File: rtl/io_mux_ctrl.sv
// Memory-mapped I/O controller: SEG/LED/SW/CTRL registers, read-back and
// switch synchroniser. Define IO_DEBOUNCE_EN to add per-bit switch debouncing.
module io_mux_ctrl
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'd32,
  parameter int          NUM_DIGITS      = 4,
  parameter int          LED_WIDTH       = 16,
  parameter int          SW_WIDTH        = 16,
  parameter int          REFRESH_DIV     = 50000,
  parameter int          DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           io_addr,
  input  logic [31:0]           io_data_in,
  input  logic                  io_w_en,
  input  logic                  io_r_en,
  output logic [31:0]           io_data_out,
  output logic                  io_r_valid,
  input  logic [SW_WIDTH-1:0]   sw_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [LED_WIDTH-1:0]  led_out
);

  logic [4*NUM_DIGITS-1:0] seg_reg;
  logic [LED_WIDTH-1:0]    led_reg;
  logic [1:0]              ctrl_reg;
  logic [SW_WIDTH-1:0]     sw_meta, sw_sync, sw_val;
  logic                    hit_seg, hit_led, hit_sw, hit_ctrl, hit_any;
  logic [31:0]             rd_val;

  always_comb begin
    hit_seg  = (io_addr == BASE_ADDR + SEG_OFS);
    hit_led  = (io_addr == BASE_ADDR + LED_OFS);
    hit_sw   = (io_addr == BASE_ADDR + SW_OFS);
    hit_ctrl = (io_addr == BASE_ADDR + CTRL_OFS);
    hit_any  = hit_seg | hit_led | hit_sw | hit_ctrl;
    rd_val   = '0;
    if (hit_seg)  rd_val[4*NUM_DIGITS-1:0] = seg_reg;
    if (hit_led)  rd_val[LED_WIDTH-1:0]    = led_reg;
    if (hit_sw)   rd_val[SW_WIDTH-1:0]     = sw_val;
    if (hit_ctrl) rd_val[1:0]              = ctrl_reg;
  end

  // Reads sample pre-edge register values, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg     <= '0;
      led_reg     <= '0;
      ctrl_reg    <= 2'b01;
      io_data_out <= '0;
      io_r_valid  <= 1'b0;
    end else begin
      if (io_w_en && hit_seg)  seg_reg  <= io_data_in[4*NUM_DIGITS-1:0];
      if (io_w_en && hit_led)  led_reg  <= io_data_in[LED_WIDTH-1:0];
      if (io_w_en && hit_ctrl) ctrl_reg <= io_data_in[1:0];
      if (io_r_en) io_data_out <= rd_val;
      io_r_valid <= io_r_en && hit_any;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt [SW_WIDTH];

  // A bit commits only after DEBOUNCE_CYCLES consecutive cycles at the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_val <= '0;
      for (int i = 0; i < SW_WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sw_sync[i] == sw_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          sw_val[i] <= sw_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign sw_val = sw_sync;
`endif

  assign led_out = led_reg;

  digit_scanner #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .digits   (seg_reg),
    .disp_en  (ctrl_reg[CTRL_DISP_EN]),
    .blank_lz (ctrl_reg[CTRL_BLANK_LZ]),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

endmodule

// File: tb/tb_io_mux_ctrl.sv
// Directed self-checking bench for io_mux_ctrl with a 4-cycle refresh divider
// and hand-computed expected register, anode and segment values.
module tb_io_mux_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_addr, io_data_in, io_data_out;
  logic        io_w_en, io_r_en, io_r_valid;
  logic [15:0] sw_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [15:0] led_out;

  int total = 0;
  int bad   = 0;

  io_mux_ctrl #(
    .BASE_ADDR       (BASE),
    .NUM_DIGITS      (4),
    .LED_WIDTH       (16),
    .SW_WIDTH        (16),
    .REFRESH_DIV     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_addr     (io_addr),
    .io_data_in  (io_data_in),
    .io_w_en     (io_w_en),
    .io_r_en     (io_r_en),
    .io_data_out (io_data_out),
    .io_r_valid  (io_r_valid),
    .sw_in       (sw_in),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    io_addr    = a;
    io_data_in = d;
    io_w_en    = 1'b1;
    tick();
    io_w_en    = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic v);
    io_addr = a;
    io_r_en = 1'b1;
    tick();
    io_r_en = 1'b0;
    d = io_data_out;
    v = io_r_valid;
  endtask

  task automatic expect_read(input string name, input logic [31:0] a,
                             input logic [31:0] exp_d, input logic exp_v);
    logic [31:0] d;
    logic        v;
    read_reg(a, d, v);
    total++;
    if (d !== exp_d || v !== exp_v) begin
      bad++;
      $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
               name, d, v, exp_d, exp_v);
    end
  endtask

  // Align to the first cycle of digit 0 (anode moves from 0111 to 1110).
  task automatic wait_digit0(output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = an_out;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (an_out == 4'b1110 && prev == 4'b0111) begin
        ok = 1'b1;
        return;
      end
      prev = an_out;
    end
  endtask

  task automatic check_scan(input string name, input logic [6:0] exp_seg [4], input int rounds);
    bit ok;
    logic [3:0] exp_an;
    int d;
    wait_digit0(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_sync: got no 0111->1110 transition, expected one within 60 cycles", name);
      return;
    end
    for (int step = 0; step < 16 * rounds; step++) begin
      if (step > 0) tick();
      d = (step / 4) % 4;
      exp_an = ~(4'b0001 << d);
      total++;
      if (an_out !== exp_an || seg_out !== exp_seg[d]) begin
        bad++;
        $display("FAIL %s step %0d: got an=%b seg=%h, expected an=%b seg=%h",
                 name, step, an_out, seg_out, exp_an, exp_seg[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io_addr = '0; io_data_in = '0; io_w_en = 1'b0; io_r_en = 1'b0; sw_in = '0;
    tick(); tick(); tick();
    total++;
    if (an_out !== 4'b1111 || led_out !== 16'h0 || io_r_valid !== 1'b0 || io_data_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got an=%b led=%h valid=%b data=%h, expected 1111 0000 0 0",
               an_out, led_out, io_r_valid, io_data_out);
    end
    rst = 1'b0;
    expect_read("reset_ctrl", BASE + 32'd12, 32'h1, 1'b1);
    tick();
    total++;
    if (io_r_valid !== 1'b0 || io_data_out !== 32'h1) begin
      bad++;
      $display("FAIL reset_valid_pulse: got valid=%b data=%h, expected valid=0 data=1",
               io_r_valid, io_data_out);
    end
    expect_read("reset_seg", BASE, 32'h0, 1'b1);
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08};  // D, C, B, A
    write_reg(BASE, 32'h0000_ABCD);
    expect_read("scan_seg_readback", BASE, 32'h0000_ABCD, 1'b1);
    check_scan("scan_abcd", exp_seg, 2);
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h12, 7'h7F, 7'h7F, 7'h7F};
    write_reg(BASE + 32'd12, 32'h3);
    write_reg(BASE, 32'h0000_0005);
    check_scan("blank_lz", exp_seg, 1);
    write_reg(BASE + 32'd12, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (an_out !== 4'b1111 || seg_out !== 7'h7F) begin
        bad++;
        $display("FAIL disp_off cycle %0d: got an=%b seg=%h, expected an=1111 seg=7f",
                 i, an_out, seg_out);
      end
      tick();
    end
    expect_read("ctrl_readback", BASE + 32'd12, 32'h0, 1'b1);
  endtask

  task automatic test_led_decode();
    write_reg(BASE + 32'd4, 32'hFFFF_FFFF);
    total++;
    if (led_out !== 16'hFFFF) begin
      bad++;
      $display("FAIL led_out: got %h, expected ffff", led_out);
    end
    expect_read("led_readback", BASE + 32'd4, 32'h0000_FFFF, 1'b1);
    write_reg(BASE + 32'd8, 32'hDEAD_BEEF);
    write_reg(BASE + 32'd2, 32'h1234_5678);
    expect_read("seg_untouched", BASE, 32'h0000_0005, 1'b1);
    expect_read("led_untouched", BASE + 32'd4, 32'h0000_FFFF, 1'b1);
    expect_read("ctrl_untouched", BASE + 32'd12, 32'h0, 1'b1);
    expect_read("sw_ro", BASE + 32'd8, 32'h0, 1'b1);
    expect_read("unaligned_read", BASE + 32'd2, 32'h0, 1'b0);
    expect_read("out_of_window", BASE + 32'd16, 32'h0, 1'b0);
  endtask

  task automatic test_switches();
`ifdef IO_DEBOUNCE_EN
    sw_in = 16'h00A5;
    repeat (5) tick();
    sw_in = 16'h0000;
    repeat (15) tick();
    expect_read("sw_glitch_filtered", BASE + 32'd8, 32'h0, 1'b1);
    sw_in = 16'h00A5;
    repeat (8) tick();
    expect_read("sw_before_debounce", BASE + 32'd8, 32'h0, 1'b1);
    tick(); tick();
    expect_read("sw_debounced", BASE + 32'd8, 32'h0000_00A5, 1'b1);
`else
    sw_in = 16'h00A5;
    expect_read("sw_latency_1", BASE + 32'd8, 32'h0, 1'b1);
    expect_read("sw_latency_2", BASE + 32'd8, 32'h0, 1'b1);
    expect_read("sw_synced", BASE + 32'd8, 32'h0000_00A5, 1'b1);
`endif
  endtask

  task automatic test_back_to_back();
    write_reg(BASE + 32'd4, 32'h1);
    io_addr    = BASE + 32'd4;
    io_data_in = 32'h2;
    io_w_en    = 1'b1;
    io_r_en    = 1'b1;
    tick();
    io_w_en    = 1'b0;
    io_r_en    = 1'b0;
    total++;
    if (io_data_out !== 32'h1 || io_r_valid !== 1'b1) begin
      bad++;
      $display("FAIL rw_same_cycle: got data=%h valid=%b, expected data=1 valid=1",
               io_data_out, io_r_valid);
    end
    expect_read("rw_next_read", BASE + 32'd4, 32'h2, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    write_reg(BASE, 32'h0000_1234);
    write_reg(BASE + 32'd4, 32'h0000_00AA);
    write_reg(BASE + 32'd12, 32'h3);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    total++;
    if (an_out !== 4'b1111 || seg_out !== 7'h7F || led_out !== 16'h0 ||
        io_r_valid !== 1'b0 || io_data_out !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: got an=%b seg=%h led=%h valid=%b data=%h, expected 1111 7f 0000 0 0",
               an_out, seg_out, led_out, io_r_valid, io_data_out);
    end
    rst = 1'b0;
    tick();
    total++;
    if (an_out !== 4'b1110 || seg_out !== 7'h40) begin
      bad++;
      $display("FAIL post_reset_digit0: got an=%b seg=%h, expected an=1110 seg=40",
               an_out, seg_out);
    end
    expect_read("post_reset_seg", BASE, 32'h0, 1'b1);
    expect_read("post_reset_led", BASE + 32'd4, 32'h0, 1'b1);
    expect_read("post_reset_ctrl", BASE + 32'd12, 32'h1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_led_decode();
    test_switches();
    test_back_to_back();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
